// File: rtl/tx_sched_pkg.sv
// Shared types and constants for the transmit scheduler: FSM states, owner
// identity, encoder packet-type codes, packet and timer widths.
package tx_pkg;

  localparam int PKT_W = 99;
  localparam int TMR_W = 6;

  localparam logic [1:0] PKT_TOKEN = 2'b01;
  localparam logic [1:0] PKT_DATA  = 2'b10;
  localparam logic [1:0] PKT_HS    = 2'b11;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd1,
    WAIT_START = 3'd2,
    SENDING    = 3'd3,
    GAP        = 3'd4
  } state_e;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

endpackage

// File: rtl/tx_sched_if.sv
// Requester and encoder signal bundle of the transmit scheduler.
// master = scheduler side, slave = requesters plus encoder.
interface tx_sched_if;
  import tx_pkg::*;

  logic             req_a;
  logic [1:0]       type_a;
  logic [PKT_W-1:0] pkt_a;
  logic             req_b;
  logic [1:0]       type_b;
  logic [PKT_W-1:0] pkt_b;
  logic             enc_busy;
  logic [PKT_W-1:0] enc_pkt;
  logic [1:0]       enc_type;
  logic             enc_avail;
  logic             done_a;
  logic             done_b;
  logic             err_a;
  logic             err_b;
  logic             sched_busy;

  modport master (
    input  req_a, type_a, pkt_a, req_b, type_b, pkt_b, enc_busy,
    output enc_pkt, enc_type, enc_avail, done_a, done_b, err_a, err_b, sched_busy
  );

  modport slave (
    output req_a, type_a, pkt_a, req_b, type_b, pkt_b, enc_busy,
    input  enc_pkt, enc_type, enc_avail, done_a, done_b, err_a, err_b, sched_busy
  );

endinterface

// File: rtl/tx_sched_timer.sv
// Saturating up-counter shared by the start-timeout and inter-frame-gap phases.
module tx_timer
  import tx_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [TMR_W-1:0] o_count
);

  logic [TMR_W-1:0] r_count;

  // Count register: clear wins over enable, holds at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= {TMR_W{1'b0}};
    end else if (i_clr) begin
      r_count <= {TMR_W{1'b0}};
    end else if (i_en && (r_count != {TMR_W{1'b1}})) begin
      r_count <= r_count + {{(TMR_W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/tx_sched.sv
// Two-requester round-robin scheduler feeding a packet encoder: latches the
// winner's packet, strobes the encoder, and reports done or start timeout.
module tx_sched
  import tx_pkg::*;
#(
  parameter int START_TIMEOUT = 16,
  parameter int IFG           = 2
) (
  input  logic      clk,
  input  logic      rst,
  tx_sched_if.master bus
);

  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(START_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] IFG_LAST = TMR_W'(IFG - 1);

  state_e           r_state;
  state_e           w_state_nx;
  owner_e           r_last_owner;
  owner_e           w_grant;
  logic             w_take;
  logic             w_done_nx;
  logic             w_err_nx;
  logic             w_tmr_clr;
  logic             w_tmr_en;
  logic [TMR_W-1:0] w_count;

  logic [PKT_W-1:0] r_enc_pkt;
  logic [1:0]       r_enc_type;
  logic             r_enc_avail;
  logic             r_done_a;
  logic             r_done_b;
  logic             r_err_a;
  logic             r_err_b;
  logic             r_sched_busy;

  tx_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_tmr_clr),
    .i_en    (w_tmr_en),
    .o_count (w_count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next state, grant decision and timer control; timer is held clear unless counting.
  always_comb begin
    w_state_nx = r_state;
    w_grant    = r_last_owner;
    w_take     = 1'b0;
    w_done_nx  = 1'b0;
    w_err_nx   = 1'b0;
    w_tmr_clr  = 1'b1;
    w_tmr_en   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req_a && bus.req_b) begin
          w_take     = 1'b1;
          w_state_nx = LOAD;
          w_grant    = (r_last_owner == OWN_A) ? OWN_B : OWN_A;
        end else if (bus.req_a || bus.req_b) begin
          w_take     = 1'b1;
          w_state_nx = LOAD;
          w_grant    = bus.req_a ? OWN_A : OWN_B;
        end else begin
          w_state_nx = IDLE;
        end
      end
      LOAD: begin
        w_state_nx = WAIT_START;
      end
      WAIT_START: begin
        if (bus.enc_busy) begin
          w_state_nx = SENDING;
        end else if (w_count == TO_LAST) begin
          w_err_nx   = 1'b1;
          w_state_nx = GAP;
        end else begin
          w_tmr_clr = 1'b0;
          w_tmr_en  = 1'b1;
        end
      end
      SENDING: begin
        if (!bus.enc_busy) begin
          w_done_nx  = 1'b1;
          w_state_nx = GAP;
        end else begin
          w_state_nx = SENDING;
        end
      end
      GAP: begin
        if (w_count == IFG_LAST) begin
          w_state_nx = IDLE;
        end else begin
          w_tmr_clr = 1'b0;
          w_tmr_en  = 1'b1;
        end
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  // Registered encoder outputs, owner pulses and ownership memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_enc_pkt    <= {PKT_W{1'b0}};
      r_enc_type   <= 2'b00;
      r_enc_avail  <= 1'b0;
      r_done_a     <= 1'b0;
      r_done_b     <= 1'b0;
      r_err_a      <= 1'b0;
      r_err_b      <= 1'b0;
      r_sched_busy <= 1'b0;
      r_last_owner <= OWN_B;
    end else begin
      r_enc_avail  <= w_take;
      r_sched_busy <= (w_state_nx != IDLE);
      r_done_a     <= w_done_nx && (r_last_owner == OWN_A);
      r_done_b     <= w_done_nx && (r_last_owner == OWN_B);
      r_err_a      <= w_err_nx  && (r_last_owner == OWN_A);
      r_err_b      <= w_err_nx  && (r_last_owner == OWN_B);
      if (w_take) begin
        r_last_owner <= w_grant;
        r_enc_pkt    <= (w_grant == OWN_A) ? bus.pkt_a  : bus.pkt_b;
        r_enc_type   <= (w_grant == OWN_A) ? bus.type_a : bus.type_b;
      end else begin
        r_last_owner <= r_last_owner;
        r_enc_pkt    <= r_enc_pkt;
        r_enc_type   <= r_enc_type;
      end
    end
  end

  assign bus.enc_pkt    = r_enc_pkt;
  assign bus.enc_type   = r_enc_type;
  assign bus.enc_avail  = r_enc_avail;
  assign bus.done_a     = r_done_a;
  assign bus.done_b     = r_done_b;
  assign bus.err_a      = r_err_a;
  assign bus.err_b      = r_err_b;
  assign bus.sched_busy = r_sched_busy;

endmodule
